// File: rtl/multdiv_scheduler.sv
// Two-port round-robin front end for the shared iterative multdiv unit.
// Holds operands, pulses start, and returns the tagged result on writeback.
module multdiv_scheduler #(
   parameter int TAG_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_op,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_op,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [31:0]      md_operandA,
   output logic [31:0]      md_operandB,
   output logic             md_ctrl_MULT,
   output logic             md_ctrl_DIV,
   input  logic [31:0]      md_result,
   input  logic             md_exception,
   input  logic             md_resultRDY,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [31:0]      wb_result,
   output logic             wb_exception,
   output logic [TAG_W-1:0] wb_tag,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic             rr;
   logic             op_q;
   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic [TAG_W-1:0] tag_q;
   logic             gnt0;
   logic             gnt1;
   logic             accept;

   always_comb begin
      gnt0         = req0_valid && (!req1_valid || !rr);
      gnt1         = req1_valid && (!req0_valid || rr);
      req0_ready   = (state == IDLE) && gnt0 && !flush && !reset;
      req1_ready   = (state == IDLE) && gnt1 && !flush && !reset;
      accept       = req0_ready || req1_ready;
      md_ctrl_MULT = (state == ISSUE) && !op_q && !reset;
      md_ctrl_DIV  = (state == ISSUE) && op_q && !reset;
      state_nx     = state;
      case (state)
         IDLE:    if (accept) state_nx = ISSUE;
         // a stale resultRDY from the previous op is ignored here
         ISSUE:   state_nx = WAIT;
         WAIT:    if (md_resultRDY) state_nx = DONE;
         DONE:    if (wb_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rr           <= 1'b0;
         op_q         <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         tag_q        <= '0;
         wb_result    <= '0;
         wb_exception <= 1'b0;
         wb_tag       <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            rr    <= req0_ready;
            op_q  <= req1_ready ? req1_op  : req0_op;
            a_q   <= req1_ready ? req1_a   : req0_a;
            b_q   <= req1_ready ? req1_b   : req0_b;
            tag_q <= req1_ready ? req1_tag : req0_tag;
         end
         if (state == WAIT && md_resultRDY && !flush) begin
            wb_result    <= md_result;
            wb_exception <= md_exception;
            wb_tag       <= tag_q;
         end
      end
   end

   assign md_operandA = a_q;
   assign md_operandB = b_q;
   assign wb_valid    = (state == DONE);
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Scoreboard bench for multdiv_scheduler with a behavioural multdiv model
// and a high-level model of grant order, in-flight status and results.
module tb_multdiv_scheduler;

   localparam int TAG_W = 6;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic             req0_valid = 1'b0;
   logic             req0_ready;
   logic             req0_op = 1'b0;
   logic [31:0]      req0_a = '0;
   logic [31:0]      req0_b = '0;
   logic [TAG_W-1:0] req0_tag = '0;
   logic             req1_valid = 1'b0;
   logic             req1_ready;
   logic             req1_op = 1'b0;
   logic [31:0]      req1_a = '0;
   logic [31:0]      req1_b = '0;
   logic [TAG_W-1:0] req1_tag = '0;
   logic [31:0]      md_operandA;
   logic [31:0]      md_operandB;
   logic             md_ctrl_MULT;
   logic             md_ctrl_DIV;
   logic [31:0]      md_result = '0;
   logic             md_exception = 1'b0;
   logic             md_resultRDY = 1'b0;
   logic             wb_valid;
   logic             wb_ready = 1'b0;
   logic [31:0]      wb_result;
   logic             wb_exception;
   logic [TAG_W-1:0] wb_tag;
   logic             busy;

   multdiv_scheduler #(.TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .req1_tag(req1_tag),
      .md_operandA(md_operandA), .md_operandB(md_operandB),
      .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
      .md_result(md_result), .md_exception(md_exception),
      .md_resultRDY(md_resultRDY),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_result(wb_result), .wb_exception(wb_exception),
      .wb_tag(wb_tag), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0]      res;
      logic             exc;
      logic [TAG_W-1:0] tag;
      logic             op;
      logic [31:0]      a;
      logic [31:0]      b;
   } exp_t;

   int               tests = 0;
   int               fails = 0;
   exp_t             sb[$];
   int               grant_log[$];
   int               tag_log[$];
   bit               in_flight = 0;
   bit               await_pulse = 0;
   bit               rr_m = 0;
   bit               acc0 = 0;
   bit               acc1 = 0;
   int               pulse_cnt = 0;
   int               div_cnt = 0;
   int               wb_cnt = 0;
   int               md_lat = 3;
   logic [31:0]      last_res = '0;
   logic             last_exc = 1'b0;
   logic [TAG_W-1:0] last_tag = '0;

   function automatic logic [32:0] ref_op(input logic op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      if (!op) begin
         r = a * b;
         return {1'b0, r};
      end
      if (b == 32'h0) return {1'b1, 32'h0};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return {1'b0, 32'h8000_0000};
      r = 32'($signed(a) / $signed(b));
      return {1'b0, r};
   endfunction

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // behavioural multdiv: fixed or random latency, ready stays high until next start
   int          md_cnt = 0;
   bit          md_run = 0;
   logic [32:0] md_pend = '0;
   always @(posedge clock) begin
      if (md_ctrl_MULT || md_ctrl_DIV) begin
         md_pend      <= ref_op(md_ctrl_DIV, md_operandA, md_operandB);
         md_cnt       <= (md_lat == 0) ? int'($urandom_range(1, 5)) : md_lat;
         md_run       <= 1;
         md_resultRDY <= 1'b0;
      end else if (md_run) begin
         if (md_cnt <= 1) begin
            md_run       <= 0;
            md_resultRDY <= 1'b1;
            md_result    <= md_pend[31:0];
            md_exception <= md_pend[32];
         end else begin
            md_cnt <= md_cnt - 1;
         end
      end
   end

   // monitor and scoreboard
   always @(negedge clock) begin
      bit   was;
      bit   pulse;
      bit   a0;
      bit   a1;
      int   g;
      int   g_exp;
      exp_t e;
      if (reset) begin
         sb.delete();
         in_flight   = 0;
         await_pulse = 0;
         rr_m        = 0;
      end else begin
         was   = in_flight;
         pulse = md_ctrl_MULT || md_ctrl_DIV;
         chk("pulse_timing", 64'(pulse), 64'(await_pulse));
         chk("pulse_onehot", 64'(md_ctrl_MULT && md_ctrl_DIV), 0);
         if (pulse) begin
            pulse_cnt++;
            if (md_ctrl_DIV) div_cnt++;
            if (sb.size() > 0) begin
               chk("pulse_op", 64'(md_ctrl_DIV), 64'(sb[0].op));
               chk("operand_a", 64'(md_operandA), 64'(sb[0].a));
               chk("operand_b", 64'(md_operandB), 64'(sb[0].b));
            end
         end
         await_pulse = 0;
         chk("busy", 64'(busy), 64'(was));
         if (was) chk("ready_while_busy", 64'({req0_ready, req1_ready}), 0);
         if (flush) chk("ready_in_flush", 64'({req0_ready, req1_ready}), 0);
         if (wb_valid && !was) chk("wb_spurious", 64'(wb_valid), 0);
         if (wb_valid && wb_ready && !flush && was && sb.size() > 0) begin
            e = sb.pop_front();
            chk("wb_result", 64'(wb_result), 64'(e.res));
            chk("wb_exception", 64'(wb_exception), 64'(e.exc));
            chk("wb_tag", 64'(wb_tag), 64'(e.tag));
            last_res = wb_result;
            last_exc = wb_exception;
            last_tag = wb_tag;
            tag_log.push_back(int'(wb_tag));
            wb_cnt++;
            in_flight = 0;
         end
         if (flush) begin
            sb.delete();
            in_flight = 0;
         end
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         if (a0 || a1) begin
            g = a1 ? 1 : 0;
            if (req0_valid && req1_valid) g_exp = rr_m ? 1 : 0;
            else g_exp = req0_valid ? 0 : 1;
            chk("single_grant", 64'(a0 && a1), 0);
            chk("grant_port", 64'(g), 64'(g_exp));
            e.op  = g ? req1_op : req0_op;
            e.a   = g ? req1_a : req0_a;
            e.b   = g ? req1_b : req0_b;
            e.tag = g ? req1_tag : req0_tag;
            {e.exc, e.res} = ref_op(e.op, e.a, e.b);
            sb.push_back(e);
            in_flight   = 1;
            await_pulse = 1;
            rr_m        = (g == 0);
            grant_log.push_back(g);
            if (g == 0) acc0 = 1;
            else acc1 = 1;
         end else if (!was && !flush && (req0_valid || req1_valid)) begin
            chk("missing_grant", 0, 1);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (acc0) begin req0_valid = 1'b0; acc0 = 0; end
      if (acc1) begin req1_valid = 1'b0; acc1 = 0; end
   endtask

   task automatic offer(input int p, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag);
      if (p == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
         req0_tag = tag;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
         req1_tag = tag;
      end
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n = 0;
      while ((in_flight || req0_valid || req1_valid) && n < bound) begin
         tick();
         n++;
      end
      tests++;
      if (in_flight || req0_valid || req1_valid) begin
         fails++;
         $display("FAIL %s: still busy after %0d cycles", name, bound);
      end
   endtask

   task automatic wait_pulse(input string name, input int bound);
      int p = pulse_cnt;
      int n = 0;
      while (pulse_cnt == p && n < bound) begin
         tick();
         n++;
      end
      chk(name, 64'(pulse_cnt != p), 1);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_req_ready"}, 64'({req0_ready, req1_ready}), 0);
      chk({name, "_ctrl"}, 64'({md_ctrl_MULT, md_ctrl_DIV}), 0);
      chk({name, "_opA"}, 64'(md_operandA), 0);
      chk({name, "_opB"}, 64'(md_operandB), 0);
      chk({name, "_wb_valid"}, 64'(wb_valid), 0);
      chk({name, "_wb_result"}, 64'(wb_result), 0);
      chk({name, "_wb_exc"}, 64'(wb_exception), 0);
      chk({name, "_wb_tag"}, 64'(wb_tag), 0);
      chk({name, "_busy"}, 64'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n0;
      int n1;
      int p0;
      int w0;
      int n;
      // reset state, with a request presented to prove ready is gated
      reset = 1'b1;
      offer(0, 1'b0, 32'd1, 32'd2, 6'd1);
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      req0_valid = 1'b0;
      reset = 1'b0;
      tick();

      // single multiply
      wb_ready = 1'b1;
      md_lat = 3;
      offer(0, 1'b0, 32'd7, 32'hFFFF_FFFD, 6'd5);
      wait_idle("single_mult", 40);
      chk("mult_result", 64'(last_res), 64'h0000_0000_FFFF_FFEB);
      chk("mult_exc", 64'(last_exc), 0);
      chk("mult_tag", 64'(last_tag), 5);

      // round robin from a fresh pointer
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      grant_log.delete();
      tag_log.delete();
      p0 = div_cnt;
      n0 = 0;
      n1 = 0;
      n = 0;
      while (n < 200) begin
         if (!req0_valid && n0 < 2) begin
            offer(0, 1'b0, 32'(n0 + 3), 32'd9, 6'(10 + 2 * n0));
            n0++;
         end
         if (!req1_valid && n1 < 2) begin
            offer(1, 1'b1, 32'd100, 32'(n1 + 4), 6'(11 + 2 * n1));
            n1++;
         end
         if (n0 == 2 && n1 == 2 && !req0_valid && !req1_valid) break;
         tick();
         n++;
      end
      wait_idle("rr_drain", 60);
      chk("rr_count", 64'(grant_log.size()), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         chk("rr_order", 64'(grant_log[i]), 64'(i % 2));
      for (int i = 0; i < 4 && i < tag_log.size(); i++)
         chk("rr_tag_order", 64'(tag_log[i]), 64'(10 + i));
      chk("rr_div_pulses", 64'(div_cnt - p0), 2);

      // divide by zero
      offer(1, 1'b1, 32'd10, 32'd0, 6'd33);
      wait_idle("div_zero", 40);
      chk("div0_exc", 64'(last_exc), 1);
      chk("div0_tag", 64'(last_tag), 33);

      // writeback backpressure with a competing request pending
      wb_ready = 1'b0;
      offer(0, 1'b0, 32'd1000, 32'hFFFF_FFFE, 6'd7);
      n = 0;
      while (req0_valid && n < 20) begin tick(); n++; end
      offer(1, 1'b0, 32'd2, 32'd3, 6'd8);
      n = 0;
      while (!wb_valid && n < 40) begin tick(); n++; end
      chk("bp_wb_seen", 64'(wb_valid), 1);
      for (int i = 0; i < 20; i++) begin
         chk("bp_wb_valid", 64'(wb_valid), 1);
         chk("bp_wb_result", 64'(wb_result), 64'h0000_0000_FFFF_F830);
         chk("bp_wb_tag", 64'(wb_tag), 7);
         chk("bp_req_ready", 64'({req0_ready, req1_ready}), 0);
         tick();
      end
      wb_ready = 1'b1;
      wait_idle("bp_drain", 60);
      chk("bp_last_tag", 64'(last_tag), 8);

      // flush during WAIT, then a fresh multiply
      md_lat = 10;
      p0 = pulse_cnt;
      w0 = wb_cnt;
      offer(0, 1'b0, 32'd3, 32'd4, 6'd1);
      wait_pulse("flush_first_pulse", 20);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 0);
      md_lat = 2;
      offer(0, 1'b0, 32'd6, 32'd6, 6'd2);
      wait_idle("flush_second", 40);
      chk("flush_wb_count", 64'(wb_cnt - w0), 1);
      chk("flush_result", 64'(last_res), 36);
      chk("flush_tag", 64'(last_tag), 2);
      chk("flush_pulses", 64'(pulse_cnt - p0), 2);

      // asynchronous reset in the middle of WAIT
      md_lat = 10;
      offer(1, 1'b1, 32'd100, 32'd7, 6'd9);
      wait_pulse("areset_pulse", 20);
      tick();
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("areset");
      p0 = pulse_cnt;
      w0 = wb_cnt;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("areset_no_wb", 64'(wb_valid), 0);
      end
      chk("areset_no_pulse", 64'(pulse_cnt - p0), 0);
      chk("areset_wb_count", 64'(wb_cnt - w0), 0);

      // randomized traffic with flush and backpressure
      md_lat = 0;
      for (int i = 0; i < 400; i++) begin
         flush = ($urandom_range(0, 39) == 0);
         wb_ready = ($urandom_range(0, 3) != 0);
         if (!req0_valid && $urandom_range(0, 2) == 0)
            offer(0, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  6'($urandom_range(0, 63)));
         if (!req1_valid && $urandom_range(0, 2) == 0)
            offer(1, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  6'($urandom_range(0, 63)));
         tick();
      end
      flush = 1'b0;
      wb_ready = 1'b1;
      wait_idle("random_drain", 200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multdiv_scheduler.md
# multdiv_scheduler

Sequencer and two-port arbiter in front of the shared iterative `multdiv` unit. It accepts multiply/divide requests from two issue ports with round-robin arbitration and holds the operands stable for the whole operation. It generates the single-cycle `ctrl_MULT`/`ctrl_DIV` start pulse, waits for `data_resultRDY`, and presents the tagged result on a valid/ready writeback port until it is accepted. A `flush` input abandons the in-flight operation for misspeculation recovery.

## Interface
- `TAG_W`, default 6: width of the destination/ROB tag carried with each request.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: abandon any accepted or in-flight operation.
- `req0_valid` in 1 / `req0_ready` out 1: port 0 handshake; transfer occurs on a cycle where both are high.
- `req0_op` in 1: 0 = multiply, 1 = divide.
- `req0_a` in 32, `req0_b` in 32: operands A and B.
- `req0_tag` in TAG_W: tag for the request.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`, `req1_tag`: identical set for port 1.
- `md_operandA` out 32, `md_operandB` out 32: registered operands to `multdiv`.
- `md_ctrl_MULT` out 1, `md_ctrl_DIV` out 1: one-cycle start pulses to `multdiv`.
- `md_result` in 32, `md_exception` in 1, `md_resultRDY` in 1: `multdiv` outputs.
- `wb_valid` out 1 / `wb_ready` in 1: writeback handshake.
- `wb_result` out 32, `wb_exception` out 1, `wb_tag` out TAG_W: writeback payload.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Four states: IDLE, ISSUE, WAIT, DONE. Reset forces IDLE.
- **IDLE**
  - `reqN_ready` = granted port && !flush.
  - Grant goes to the single valid port.
  - If both ports are valid, grant goes to the port selected by the priority pointer `rr`. `rr` resets to 0.
  - On accept: latch op, a, b and tag; set `rr` to the non-granted port; go to ISSUE.
- **ISSUE** (exactly one cycle)
  - Drive `md_ctrl_MULT` = !op and `md_ctrl_DIV` = op. At most one is ever high.
  - `md_resultRDY` is ignored in this cycle, because a stale ready from the prior operation may still be high.
  - Go to WAIT.
- **WAIT**
  - When `md_resultRDY` = 1: capture `md_result` into `wb_result`, `md_exception` into `wb_exception`, and the latched tag into `wb_tag`; go to DONE.
- **DONE**
  - `wb_valid` = 1 and the payload is held stable.
  - When `wb_ready` = 1: go to IDLE.
  - No new request is accepted in DONE.
- **Operand outputs:** `md_operandA`/`md_operandB` come from the latch and stay constant from ISSUE through DONE. Their reset value is 0.
- **Flush**
  - Flush in any state forces IDLE at the next edge and drops `wb_valid` at that edge.
  - No request is accepted in a cycle where flush is high.
  - Flush during ISSUE still emits that cycle's pulse. The `multdiv` result is discarded, and the next ISSUE restarts the unit.
  - Flush has priority over every other transition, including a simultaneous `wb_ready`. The transfer is not counted and the consumer must also honour flush.
- **Reset mid-operation:** state returns to IDLE and all outputs take their reset values. No pulse is emitted after reset asserts.
- **Reset values:** `reqN_ready` 0, `md_ctrl_*` 0, `md_operand*` 0, `wb_valid` 0, `wb_result` 0, `wb_exception` 0, `wb_tag` 0, `busy` 0, `rr` 0.

## Timing
- Accept at edge E0, which enters ISSUE. The pulse is high during cycle E0→E1.
- WAIT starts at E1.
- `md_resultRDY` is first sampled high at edge Ek, which enters DONE. `wb_valid` is high from Ek.
- Minimum accept-to-`wb_valid` latency is 2 cycles plus the `multdiv` latency.
- If `wb_ready` is held high, `wb_valid` lasts one cycle. The next accept occurs at Ek+1 or later, giving back-to-back spacing of one IDLE cycle.
- `reqN_ready` and `md_ctrl_*` are combinational decodes of registered state and the request inputs. No other output depends combinationally on any input.

## Test plan
- **Single multiply:** port 0 issues mult a=7, b=−3, tag=5 → one-cycle `md_ctrl_MULT` pulse. Then `wb_valid` with `wb_result`=−21 (0xFFFFFFEB), `wb_exception`=0, `wb_tag`=5.
- **Round-robin:** both ports valid continuously, four requests, no flush → grant order 0,1,0,1. Tags return in the same order and `md_ctrl_DIV` is asserted for the div ops.
- **Divide by zero:** port 1 issues div a=10, b=0 → `wb_exception`=1 and `wb_tag` matches the request.
- **Writeback backpressure:** `wb_ready` held 0 for 20 cycles after DONE → `wb_valid`, `wb_result` and `wb_tag` stay stable, and `req*_ready` stays 0 throughout.
- **Flush during WAIT:** flush 3 cycles after the pulse, then a new mult 6×6 → no writeback for the first op, a fresh pulse is issued, and the result is 36.
- **Async reset:** reset asserted mid-WAIT between clock edges → all outputs reach their reset values immediately, with no pulse and no `wb_valid` afterwards.
